clk_en_divider: RTL and testbench

Parametrised multi-channel clock-enable generator that derives NUM_CH lower-rate timing references from the single system clock. Each channel has a runtime-programmable integer divide ratio and produces a one-cycle clock-enable pulse plus a registered near-50%-duty divided waveform. All channels restart phase-aligned on a configuration load, and a lock indicator reports when outputs are stable. It sits directly after the board clock input and feeds downstream logic that runs at 5 MHz / 1 MHz / 0.5 MHz-class rates, without extra clock domains.

---
 rtl/clk_en_divider.sv | 129 ++++++++++++
 tb/tb_clk_en_divider.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_divider.sv
// Multi-channel clock-enable divider: per-channel runtime ratio, one-cycle enable
// pulse and registered near-50% divided waveform, phase-aligned restart and lock flag.

module clk_en_divider_ch #(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             ce,
    output logic             clk_o
);
    localparam logic [DIV_W-1:0] RST_N = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] RST_P = DIV_W'(DIV_RST - 1);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] p_q, p_d;
    logic             ce_q, ce_d;
    logic             clk_q, clk_d;
    logic [DIV_W-1:0] p_inc;
    logic [DIV_W-1:0] n_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q   <= RST_N;
            p_q   <= RST_P;
            ce_q  <= 1'b0;
            clk_q <= 1'b0;
        end else begin
            n_q   <= n_d;
            p_q   <= p_d;
            ce_q  <= ce_d;
            clk_q <= clk_d;
        end
    end

    always_comb begin
        n_d   = n_q;
        p_d   = p_q;
        ce_d  = 1'b0;
        clk_d = clk_q;
        p_inc = (p_q == n_q - ONE) ? '0 : p_q + ONE;
        n_new = (div_in == '0) ? ONE : div_in;
        if (load) begin
            // Restart presents phase 0 of the new ratio on the load edge itself.
            n_d   = n_new;
            p_d   = '0;
            ce_d  = en;
            clk_d = (n_new >> 1) != '0;
        end else if (en) begin
            p_d   = p_inc;
            ce_d  = (p_inc == '0);
            clk_d = p_inc < (n_q >> 1);
        end
    end

    assign ce    = ce_q;
    assign clk_o = clk_q;
endmodule

module clk_en_divider #(
    parameter int NUM_CH   = 3,
    parameter int DIV_W    = 16,
    parameter int DIV_RST  = 10,
    parameter int LOCK_DLY = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    cfg_load,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       clk_out,
    output logic                    locked
);
    localparam int LCK_W = $clog2(LOCK_DLY + 1);
    localparam logic [LCK_W-1:0] LCK_MAX = LCK_W'(LOCK_DLY);

    logic [LCK_W-1:0] lck_cnt_q, lck_cnt_d;
    logic             locked_q, locked_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clk_en_divider_ch #(
                .DIV_W  (DIV_W),
                .DIV_RST(DIV_RST)
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .load  (cfg_load),
                .div_in(div_cfg[gi*DIV_W +: DIV_W]),
                .ce    (ce_out[gi]),
                .clk_o (clk_out[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lck_cnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            lck_cnt_q <= lck_cnt_d;
            locked_q  <= locked_d;
        end
    end

    // The load edge itself does not count toward lock; counting starts on the next en edge.
    always_comb begin
        lck_cnt_d = lck_cnt_q;
        locked_d  = locked_q;
        if (cfg_load) begin
            lck_cnt_d = '0;
            locked_d  = 1'b0;
        end else if (en) begin
            if (lck_cnt_q != LCK_MAX)
                lck_cnt_d = lck_cnt_q + LCK_W'(1);
            locked_d = (lck_cnt_d == LCK_MAX);
        end
    end

    assign locked = locked_q;
endmodule

// File: tb/tb_clk_en_divider.sv
// Directed self-checking bench for clk_en_divider (3 channels, reset ratio 10, lock delay 16).

module tb_clk_en_divider;
    logic        clk;
    logic        rst;
    logic        en;
    logic [47:0] div_cfg;
    logic        cfg_load;
    logic [2:0]  ce_out;
    logic [2:0]  clk_out;
    logic        locked;

    int errors = 0;
    int checks = 0;

    clk_en_divider #(
        .NUM_CH  (3),
        .DIV_W   (16),
        .DIV_RST (10),
        .LOCK_DLY(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_cfg (div_cfg),
        .cfg_load(cfg_load),
        .ce_out  (ce_out),
        .clk_out (clk_out),
        .locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at phase ph (enabled edges since phase 0) for ratios n0..n2.
    function automatic logic [2:0] ev_ce(int ph, int n0, int n1, int n2);
        return {ph % n2 == 0, ph % n1 == 0, ph % n0 == 0};
    endfunction

    function automatic logic [2:0] ev_clk(int ph, int n0, int n1, int n2);
        return {(ph % n2) < n2 / 2, (ph % n1) < n1 / 2, (ph % n0) < n0 / 2};
    endfunction

    task automatic do_load(input logic [47:0] cfg);
        div_cfg  = cfg;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; div_cfg = '0;
        #12;
        checks++; if (ce_out !== 3'b000) begin errors++; $display("FAIL reset_ce got=%b exp=000", ce_out); end
        checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL reset_clk got=%b exp=000", clk_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (ce_out !== ev_ce(k - 1, 10, 10, 10)) begin
                errors++; $display("FAIL rst_run_ce k=%0d got=%b exp=%b", k, ce_out, ev_ce(k - 1, 10, 10, 10));
            end
            checks++;
            if (clk_out !== ev_clk(k - 1, 10, 10, 10)) begin
                errors++; $display("FAIL rst_run_clk k=%0d got=%b exp=%b", k, clk_out, ev_clk(k - 1, 10, 10, 10));
            end
            checks++;
            if (locked !== (k >= 16)) begin
                errors++; $display("FAIL rst_run_locked k=%0d got=%b exp=%b", k, locked, k >= 16);
            end
        end
    endtask

    task automatic test_load_ratios();
        do_load({16'd100, 16'd50, 16'd10});
        for (int ph = 0; ph <= 210; ph++) begin
            if (ph > 0) tick();
            checks++;
            if (ce_out !== ev_ce(ph, 10, 50, 100)) begin
                errors++; $display("FAIL load_ce ph=%0d got=%b exp=%b", ph, ce_out, ev_ce(ph, 10, 50, 100));
            end
            checks++;
            if (clk_out !== ev_clk(ph, 10, 50, 100)) begin
                errors++; $display("FAIL load_clk ph=%0d got=%b exp=%b", ph, clk_out, ev_clk(ph, 10, 50, 100));
            end
            checks++;
            if (locked !== (ph >= 16)) begin
                errors++; $display("FAIL load_locked ph=%0d got=%b exp=%b", ph, locked, ph >= 16);
            end
        end
    endtask

    task automatic test_zero_one_seven();
        // Ratio 0 must behave exactly like ratio 1.
        do_load({16'd7, 16'd1, 16'd0});
        for (int ph = 0; ph <= 30; ph++) begin
            if (ph > 0) tick();
            checks++;
            if (ce_out !== ev_ce(ph, 1, 1, 7)) begin
                errors++; $display("FAIL z17_ce ph=%0d got=%b exp=%b", ph, ce_out, ev_ce(ph, 1, 1, 7));
            end
            checks++;
            if (clk_out !== ev_clk(ph, 1, 1, 7)) begin
                errors++; $display("FAIL z17_clk ph=%0d got=%b exp=%b", ph, clk_out, ev_clk(ph, 1, 1, 7));
            end
        end
    endtask

    task automatic test_en_gap();
        int ph;
        do_load({16'd10, 16'd10, 16'd10});
        ph = 0;
        for (int w = 1; w <= 35; w++) begin
            en = !(w >= 4 && w < 9);
            tick();
            if (en) ph++;
            checks++;
            if (ce_out !== (en ? ev_ce(ph, 10, 10, 10) : 3'b000)) begin
                errors++; $display("FAIL gap_ce w=%0d got=%b exp=%b", w, ce_out, en ? ev_ce(ph, 10, 10, 10) : 3'b000);
            end
            checks++;
            if (clk_out !== ev_clk(ph, 10, 10, 10)) begin
                errors++; $display("FAIL gap_clk w=%0d got=%b exp=%b", w, clk_out, ev_clk(ph, 10, 10, 10));
            end
            checks++;
            if (locked !== (ph >= 16)) begin
                errors++; $display("FAIL gap_locked w=%0d got=%b exp=%b", w, locked, ph >= 16);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_load_idle();
        en = 1'b0;
        do_load({16'd4, 16'd4, 16'd4});
        checks++; if (ce_out !== 3'b000) begin errors++; $display("FAIL idle_load_ce got=%b exp=000", ce_out); end
        checks++; if (clk_out !== 3'b111) begin errors++; $display("FAIL idle_load_clk got=%b exp=111", clk_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_load_locked got=%b exp=0", locked); end
        // Ratio changes without a load strobe must be ignored.
        div_cfg = {16'd3, 16'd3, 16'd3};
        tick(); tick();
        checks++; if (ce_out !== 3'b000) begin errors++; $display("FAIL idle_hold_ce got=%b exp=000", ce_out); end
        en = 1'b1;
        for (int ph = 1; ph <= 12; ph++) begin
            tick();
            checks++;
            if (ce_out !== ev_ce(ph, 4, 4, 4)) begin
                errors++; $display("FAIL idle_run_ce ph=%0d got=%b exp=%b", ph, ce_out, ev_ce(ph, 4, 4, 4));
            end
            checks++;
            if (clk_out !== ev_clk(ph, 4, 4, 4)) begin
                errors++; $display("FAIL idle_run_clk ph=%0d got=%b exp=%b", ph, clk_out, ev_clk(ph, 4, 4, 4));
            end
        end
    endtask

    task automatic test_relock();
        do_load({16'd10, 16'd10, 16'd10});
        for (int ph = 1; ph <= 20; ph++) tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_pre got=%b exp=1", locked); end
        do_load({16'd10, 16'd10, 16'd10});
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_drop got=%b exp=0", locked); end
        checks++; if (ce_out !== 3'b111) begin errors++; $display("FAIL relock_ce1 got=%b exp=111", ce_out); end
        tick(); tick();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_mid got=%b exp=0", locked); end
        do_load({16'd10, 16'd10, 16'd10});
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_second got=%b exp=0", locked); end
        checks++; if (ce_out !== 3'b111) begin errors++; $display("FAIL relock_ce2 got=%b exp=111", ce_out); end
        for (int ph = 1; ph <= 20; ph++) begin
            tick();
            checks++;
            if (locked !== (ph >= 16)) begin
                errors++; $display("FAIL relock_run ph=%0d got=%b exp=%b", ph, locked, ph >= 16);
            end
        end
    endtask

    task automatic test_async_reset();
        // Entered at phase 20 of ratio 10: ce, clk_out and locked all high.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ce_out !== 3'b000) begin errors++; $display("FAIL arst_ce got=%b exp=000", ce_out); end
        checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL arst_clk got=%b exp=000", clk_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got=%b exp=0", locked); end
        @(negedge clk);
        rst = 1'b0;
        div_cfg = {16'd7, 16'd7, 16'd7};
        for (int k = 1; k <= 22; k++) begin
            tick();
            checks++;
            if (ce_out !== ev_ce(k - 1, 10, 10, 10)) begin
                errors++; $display("FAIL arst_run_ce k=%0d got=%b exp=%b", k, ce_out, ev_ce(k - 1, 10, 10, 10));
            end
            checks++;
            if (clk_out !== ev_clk(k - 1, 10, 10, 10)) begin
                errors++; $display("FAIL arst_run_clk k=%0d got=%b exp=%b", k, clk_out, ev_clk(k - 1, 10, 10, 10));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_ratios();
        test_zero_one_seven();
        test_en_gap();
        test_load_idle();
        test_relock();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
